// File: rtl/truth_table_extractor.sv
// truth_table_extractor
//   Recovers the truth-table code of an N_IN-input, single-output combinational
//   circuit. Each input row is driven in turn, dut_out is ignored for
//   SETTLE_CYCLES edges, then sampled on SAMPLES edges and majority voted.
//   Row 0 (all inputs low) lands in the MSB of the code. The recovered code is
//   optionally compared against an expected code captured at start.
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       begin extraction (accepted only when idle)
//   exp_code    expected code, captured when start is accepted
//   dut_out     output of the circuit under characterisation
//   in_drive    circuit inputs, in_drive[N_IN-1] is the row MSB
//   busy        high from start acceptance until done
//   done        one-cycle pulse when tt_code is updated
//   tt_code     recovered code, held until the next done
//   match       tt_code equals the captured exp_code (valid while code_valid)
//   code_valid  high once any extraction has completed since reset
module truth_table_extractor #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_code,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      in_drive,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt_code,
  output logic                 match,
  output logic                 code_valid
);

  localparam int unsigned W  = 2**N_IN;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int unsigned VW = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CW-1:0]   samp_q, samp_d;
  logic [VW-1:0]   ones_q, ones_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    tt_q, tt_d;
  logic            match_q, match_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Vote including the sample taken on the current edge.
  logic [VW:0]     ones_sum;
  logic            row_bit;
  logic [N_IN-1:0] bit_idx;
  logic [W-1:0]    shadow_bit;

  always_comb begin
    ones_sum   = {1'b0, ones_q} + (VW+1)'(dut_out);
    row_bit    = ones_sum > (VW+1)'(SAMPLES / 2);
    // W-1-r equals the bitwise inverse of r for r < W.
    bit_idx    = ~row_q[N_IN-1:0];
    shadow_bit = shadow_q;
    shadow_bit[bit_idx] = row_bit;

    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    ones_d   = ones_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    match_d  = match_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          row_d    = '0;
          exp_d    = exp_code;
          shadow_d = '0;
          settle_d = '0;
          samp_d   = '0;
          ones_d   = '0;
          state_d  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (samp_q == CW'(SAMPLES - 1)) begin
          samp_d   = '0;
          ones_d   = '0;
          shadow_d = shadow_bit;
          if (row_q == (N_IN+1)'(W - 1)) begin
            tt_d    = shadow_bit;
            match_d = (shadow_bit == exp_q);
            valid_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
          end
        end else begin
          samp_d = samp_q + 1'b1;
          ones_d = ones_sum[VW-1:0];
        end
      end
      // Holds off a start arriving in the same cycle as done.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      ones_q   <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      ones_q   <= ones_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in_drive   = row_q[N_IN-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign tt_code    = tt_q;
  assign match      = match_q;
  assign code_valid = valid_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench for truth_table_extractor: a default instance
// (3 inputs, settle 4, 3 samples) and a fast instance (settle 0, 1 sample)
// each drive a modelled gate circuit with optional propagation delay and glitches.
module tb_truth_table_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, dut_out;
  logic [7:0] exp_code;
  logic [2:0] in_drive;
  logic       busy, done, match, code_valid;
  logic [7:0] tt_code;

  logic       start_f, dut_out_f;
  logic [7:0] exp_f;
  logic [2:0] in_drive_f;
  logic       busy_f, done_f, match_f, valid_f;
  logic [7:0] tt_f;

  truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(4), .SAMPLES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_code(exp_code), .dut_out(dut_out),
    .in_drive(in_drive), .busy(busy), .done(done), .tt_code(tt_code),
    .match(match), .code_valid(code_valid));

  truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(0), .SAMPLES(1)) dut_fast (
    .clk(clk), .rst(rst), .start(start_f), .exp_code(exp_f), .dut_out(dut_out_f),
    .in_drive(in_drive_f), .busy(busy_f), .done(done_f), .tt_code(tt_f),
    .match(match_f), .code_valid(valid_f));

  // Circuit under characterisation: table or gate function, 0..2 cycle delay, glitch.
  logic [7:0]  circ_code;
  logic        gate_mode, glitch;
  int unsigned dly;
  logic [2:0]  d1, d2, seen, f1, f2;
  logic        ga, gb, gc;

  always @(posedge clk) begin
    d1 <= in_drive;   d2 <= d1;
    f1 <= in_drive_f; f2 <= f1;
  end

  always_comb begin
    seen = (dly == 0) ? in_drive : (dly == 1) ? d1 : d2;
    ga = seen[2]; gb = seen[1]; gc = seen[0];
    dut_out = (gate_mode ? (~(~ga & ~gb & ~gc) & ~(ga & (gb ^ gc)))
                         : circ_code[3'd7 - seen]) ^ glitch;
    dut_out_f = circ_code[3'd7 - f2];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: evaluate the circuit function row by row, row 0 into the MSB.
  function automatic logic [7:0] ref_code(input logic gate, input logic [7:0] tbl);
    logic [7:0] c;
    logic [2:0] v;
    for (int r = 0; r < 8; r++) begin
      v = 3'(r);
      c[7-r] = gate ? (((v != 3'd0) && !(v[2] && (v[1] ^ v[0]))) ? 1'b1 : 1'b0)
                    : tbl[7-r];
    end
    return c;
  endfunction

  // Fast instance sees its input two edges late: row r samples row max(r-2,0).
  function automatic logic [7:0] ref_fast(input logic [7:0] tbl);
    logic [7:0] c;
    int src;
    for (int r = 0; r < 8; r++) begin
      src = (r < 2) ? 0 : r - 2;
      c[7-r] = tbl[7-src];
    end
    return c;
  endfunction

  task automatic run_default(input logic [7:0] expc, input logic [7:0] want,
                             input bit glitch_en, input bit extra_starts);
    int slot[8];
    for (int r = 0; r < 8; r++) slot[r] = int'($urandom_range(0, 2));
    exp_code = expc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_at_start", busy, 1);
    check("row0_drive", in_drive, 0);
    exp_code = ~expc;
    for (int e = 1; e <= 56; e++) begin
      start  = extra_starts && (e == 10 || e == 30);
      glitch = glitch_en && (((e - 1) % 7) == 4 + slot[(e - 1) / 7]);
      @(posedge clk); #1;
      start = 1'b0; glitch = 1'b0;
      if (e < 56) begin
        check("in_drive_row", in_drive, e / 7);
        if (e % 8 == 0) begin
          check("no_early_done", done, 0);
          check("tt_stable", tt_code, last_code);
        end
      end
    end
    check("done_at_56", done, 1);
    check("tt_code", tt_code, want);
    check("match", match, (want == expc) ? 1 : 0);
    check("code_valid", code_valid, 1);
    check("busy_end", busy, 0);
    check("drive_end", in_drive, 0);
    last_code = want;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        gate;
    logic [7:0]  expc;
    int unsigned delay;
    bit          glitch;
    bit          extra;
    logic [7:0]  want_tt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h00, 1'b1, 8'h79, 0, 1'b0, 1'b0, 8'h79};
    vecs[1] = '{8'h01, 1'b0, 8'h01, 0, 1'b0, 1'b0, 8'h01};
    vecs[2] = '{8'h00, 1'b0, 8'hFF, 0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{8'h79, 1'b0, 8'h79, 2, 1'b0, 1'b0, 8'h79};
    vecs[4] = '{8'h00, 1'b1, 8'h79, 0, 1'b1, 1'b0, 8'h79};
    vecs[5] = '{8'h00, 1'b1, 8'h79, 1, 1'b0, 1'b1, 8'h79};

    rst = 1'b1; start = 1'b0; start_f = 1'b0; exp_code = '0; exp_f = '0;
    circ_code = '0; gate_mode = 1'b0; glitch = 1'b0; dly = 0; last_code = '0;
    #12;
    check("rst_in_drive", in_drive, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tt", tt_code, 0);
    check("rst_match", match, 0);
    check("rst_valid", code_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      circ_code = vecs[i].code; gate_mode = vecs[i].gate; dly = vecs[i].delay;
      run_default(vecs[i].expc, vecs[i].want_tt, vecs[i].glitch, vecs[i].extra);
    end

    // Randomized circuits against the row-by-row reference.
    for (int k = 0; k < 6; k++) begin
      logic [7:0] code, expc;
      code = 8'($urandom);
      expc = ($urandom_range(0, 1) == 1) ? code : 8'($urandom);
      circ_code = code; gate_mode = 1'b0; dly = $urandom_range(0, 2);
      run_default(expc, ref_code(1'b0, code), $urandom_range(0, 1) == 1, 1'b0);
    end

    // Asynchronous reset mid-run, then a fresh full run.
    circ_code = 8'h79; gate_mode = 1'b0; dly = 0;
    exp_code = 8'h79; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_in_drive", in_drive, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_tt", tt_code, 0);
    check("abort_match", match, 0);
    check("abort_valid", code_valid, 0);
    @(negedge clk); rst = 1'b0;
    last_code = '0;
    @(posedge clk); #1;
    run_default(8'h79, 8'h79, 1'b0, 1'b0);

    // No settle and one sample with a 2-cycle circuit delay gives a skewed code.
    begin
      int i;
      circ_code = 8'h79; exp_f = 8'h79; start_f = 1'b1;
      @(posedge clk); #1;
      start_f = 1'b0;
      i = 0;
      while (!done_f && i < 20) begin
        @(posedge clk); #1;
        i++;
      end
      check("fast_done", done_f, 1);
      check("fast_latency", i, 8);
      check("fast_tt", tt_f, ref_fast(8'h79));
      check("fast_match", match_f, (ref_fast(8'h79) == 8'h79) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
